// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows 32-bit store data to word/half/byte lanes and runs the data-memory req/ack handshake
module store_narrow_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  err_code
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        w_acc;
  logic        w_rsv;
  logic        w_mis;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  assign st_ready = r_state == IDLE;
  assign w_acc    = st_valid && st_ready;
  assign w_rsv    = st_op == 2'b11;
  assign w_mis    = (st_op == 2'b00 && st_addr[1:0] != 2'b00) || (st_op == 2'b01 && st_addr[0]);
  assign w_wdata  = st_op == 2'b00 ? st_wdata : st_op == 2'b01 ? {2{st_wdata[15:0]}} : {4{st_wdata[7:0]}};
  assign w_be     = st_op == 2'b00 ? 4'b1111 : st_op == 2'b01 ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << st_addr[1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      mem_req   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (r_state)
        IDLE: if (w_acc) begin
          if (w_rsv || w_mis) begin
            st_err   <= 1'b1;
            err_code <= w_rsv ? 2'b10 : 2'b01;
          end else begin
            mem_req   <= 1'b1;
            mem_addr  <= {st_addr[31:2], 2'b00};
            mem_wdata <= w_wdata;
            mem_be    <= w_be;
            err_code  <= 2'b00;
            r_cnt     <= 8'd0;
            r_state   <= REQ;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            st_done <= 1'b1;
            r_state <= IDLE;
          end else if (r_cnt + 8'd1 == 8'(ACK_TIMEOUT)) begin
            mem_req  <= 1'b0;
            st_err   <= 1'b1;
            err_code <= 2'b11;
            r_state  <= RESP;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed and random stores checked against a byte-lane reference model
module tb_store_narrow_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        mem_ack = 1'b0;
  logic [1:0]  st_op = 2'b00;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_wdata = 32'd0;
  logic        st_ready, mem_req, st_done, st_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  err_code;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  store_narrow_unit #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
    .st_addr(st_addr), .st_wdata(st_wdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .st_done(st_done),
    .st_err(st_err), .err_code(err_code)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Access of sz bytes covers lanes [base, base+sz); each lane carries byte (lane % sz) of the source.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                                output logic [1:0] ec, output logic [3:0] be, output logic [31:0] wd);
    int sz, off, base;
    be = 4'd0;
    wd = 32'd0;
    ec = 2'd2;
    if (op == 2'b11) return;
    sz = 4 >> op;
    off = int'(a[1:0]);
    ec = (off % sz != 0) ? 2'd1 : 2'd0;
    base = off / sz * sz;
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= base && i < base + sz);
      wd[8*i +: 8] = d[8*(i % sz) +: 8];
    end
  endfunction
  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, st_ready, 1);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_done"}, st_done, 0);
    chk({tag, "_err"}, st_err, 0);
    chk({tag, "_code"}, err_code, 0);
  endtask
  // dly = REQ cycle index at which ack is given; negative means never (timeout)
  task automatic do_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input int dly);
    logic [1:0] ec;
    logic [3:0] be;
    logic [31:0] wd;
    int w;
    model(op, a, d, ec, be, wd);
    w = 0;
    while (!st_ready && w < 50) begin
      tick();
      w++;
    end
    chk("ready_wait", st_ready, 1);
    st_valid = 1'b1;
    st_op = op;
    st_addr = a;
    st_wdata = d;
    tick();
    st_valid = 1'b0;
    st_op = 2'($urandom);
    st_addr = $urandom;
    st_wdata = $urandom;
    if (ec != 2'd0) begin
      chk("err_pulse", st_err, 1);
      chk("err_code", err_code, ec);
      chk("err_noreq", mem_req, 0);
      chk("err_nodone", st_done, 0);
      tick();
      chk("err_once", st_err, 0);
      chk("err_hold", err_code, ec);
      chk("err_noreq2", mem_req, 0);
      return;
    end
    chk("code_clr", err_code, 0);
    chk("busy", st_ready, 0);
    for (int k = 0; k < 15; k++) begin
      chk("req", mem_req, 1);
      chk("addr", mem_addr, {a[31:2], 2'b00});
      chk("wdata", mem_wdata, wd);
      chk("be", mem_be, be);
      chk("req_nodone", st_done, 0);
      chk("req_noerr", st_err, 0);
      if (k == dly) mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      if (k == dly) begin
        chk("done", st_done, 1);
        chk("done_noreq", mem_req, 0);
        chk("done_noerr", st_err, 0);
        chk("done_ready", st_ready, 1);
        return;
      end
    end
    chk("to_err", st_err, 1);
    chk("to_code", err_code, 3);
    chk("to_noreq", mem_req, 0);
    chk("to_resp", st_ready, 0);
    chk("to_nodone", st_done, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("to_once", st_err, 0);
    chk("to_ready", st_ready, 1);
    chk("resp_ack_ignored", st_done, 0);
    chk("to_code_hold", err_code, 3);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2 rst = 1'b1;
    #1 check_reset_values("rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_values("post_rst");
    do_store(2'b00, 32'h0000_1004, 32'h8000_1234, 0);
    do_store(2'b10, 32'h0000_2003, 32'hFFFF_FF80, 1);
    do_store(2'b01, 32'h0000_2002, 32'h0000_8000, 0);
    do_store(2'b01, 32'h0000_0001, 32'h1234_5678, 0);
    do_store(2'b00, 32'h0000_0002, 32'h1234_5678, 0);
    do_store(2'b11, 32'h0000_0100, 32'h1234_5678, 0);
    do_store(2'b00, 32'h0000_3008, 32'hCAFE_F00D, -1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_nodone", st_done, 0);
    chk("idle_ack_noreq", mem_req, 0);
    st_valid = 1'b1;
    st_op = 2'b00;
    st_addr = 32'h0000_4000;
    st_wdata = 32'h1111_2222;
    tick();
    st_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_req", mem_req, 1);
    #3 rst = 1'b1;
    #1 check_reset_values("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("rst_ack_nodone", st_done, 0);
    chk("rst_ack_noreq", mem_req, 0);
    tick();
    check_reset_values("rst_after");
    do_store(2'b10, 32'h0000_0010, 32'h0000_00A5, 2);
    do_store(2'b10, 32'h0000_0011, 32'h0000_005A, 2);
    for (int n = 0; n < 60; n++) begin
      do_store(2'($urandom_range(0, 3)), $urandom, $urandom,
               ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
